// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode encodings and datapath sizes for the decode slice
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_NOP = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   localparam int REG_W   = 8;
   localparam int NREGS   = 8;
   localparam int RADDR_W = 3;

   function automatic logic op_writes_reg(input logic [1:0] op);
      return (op == OP_ADD) || (op == OP_LDI);
   endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Two async read ports, one sync write port, write-to-read bypass
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
   import mips_pkg::*;
#(
   parameter int WIDTH = REG_W,
   parameter int DEPTH = NREGS,
   parameter int AW    = RADDR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    i_rd_addr_a,
   input  logic [AW-1:0]    i_rd_addr_b,
   output logic [WIDTH-1:0] o_rd_data_a,
   output logic [WIDTH-1:0] o_rd_data_b,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // A same-cycle write is returned directly so decode never sees stale data
   always_comb begin
      o_rd_data_a = r_mem[i_rd_addr_a];
      o_rd_data_b = r_mem[i_rd_addr_b];
      if (i_wr_en && (i_wr_addr == i_rd_addr_a)) begin
         o_rd_data_a = i_wr_data;
      end
      if (i_wr_en && (i_wr_addr == i_rd_addr_b)) begin
         o_rd_data_b = i_wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : Decode stage with register file, jump resolution and ID/EX reg
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
   parameter int REG_W = 8,
   parameter int NREGS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [1:0]               opcode,
   input  logic [$clog2(NREGS)-1:0] rDest,
   input  logic [$clog2(NREGS)-1:0] rSrc,
   input  logic [2:0]               immediate_data,
   input  logic [REG_W-1:0]         jump_address,
   input  logic                     stall,
   output logic                     in_ready,
   input  logic                     wb_en,
   input  logic [$clog2(NREGS)-1:0] wb_addr,
   input  logic [REG_W-1:0]         wb_data,
   output logic                     ex_valid,
   output logic [1:0]               ex_opcode,
   output logic [$clog2(NREGS)-1:0] ex_rdest,
   output logic [REG_W-1:0]         ex_op_a,
   output logic [REG_W-1:0]         ex_op_b,
   output logic                     ex_write_en,
   output logic                     jump_taken,
   output logic [REG_W-1:0]         jump_target
);

   import mips_pkg::*;

   localparam int c_AW = $clog2(NREGS);

   logic [REG_W-1:0] w_rd_a;
   logic [REG_W-1:0] w_rd_b;
   logic             w_acc;
   logic             w_is_jmp;
   logic [REG_W-1:0] w_op_a;
   logic [REG_W-1:0] w_op_b;

   logic             r_squash;
   logic             r_ex_valid;
   logic [1:0]       r_ex_opcode;
   logic [c_AW-1:0]  r_ex_rdest;
   logic [REG_W-1:0] r_ex_op_a;
   logic [REG_W-1:0] r_ex_op_b;
   logic             r_ex_write_en;
   logic             r_jump_taken;
   logic [REG_W-1:0] r_jump_target;

   register_file #(
      .WIDTH (REG_W),
      .DEPTH (NREGS),
      .AW    (c_AW)
   ) u_register_file (
      .clk         (clk),
      .reset       (reset),
      .i_rd_addr_a (rDest),
      .i_rd_addr_b (rSrc),
      .o_rd_data_a (w_rd_a),
      .o_rd_data_b (w_rd_b),
      .i_wr_en     (wb_en),
      .i_wr_addr   (wb_addr),
      .i_wr_data   (wb_data)
   );

   assign in_ready = ~stall;
   assign w_acc    = in_valid & ~stall & ~r_squash;
   assign w_is_jmp = (opcode == OP_JMP);

   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      case (opcode)
         OP_ADD: begin
            w_op_a = w_rd_a;
            w_op_b = w_rd_b;
         end
         OP_LDI: begin
            w_op_b = {{(REG_W-3){1'b0}}, immediate_data};
         end
         default: begin
            w_op_a = '0;
            w_op_b = '0;
         end
      endcase
   end

   // Squash drops the one instruction fetched before the PC redirect lands
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_squash      <= 1'b0;
         r_jump_taken  <= 1'b0;
         r_jump_target <= '0;
      end else begin
         r_jump_taken <= w_acc & w_is_jmp;
         if (w_acc && w_is_jmp) begin
            r_jump_target <= jump_address;
         end
         if (r_squash && in_valid && !stall) begin
            r_squash <= 1'b0;
         end else if (w_acc && w_is_jmp) begin
            r_squash <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_valid    <= 1'b0;
         r_ex_opcode   <= '0;
         r_ex_rdest    <= '0;
         r_ex_op_a     <= '0;
         r_ex_op_b     <= '0;
         r_ex_write_en <= 1'b0;
      end else if (!stall) begin
         if (w_acc && !w_is_jmp) begin
            r_ex_valid    <= 1'b1;
            r_ex_opcode   <= opcode;
            r_ex_rdest    <= rDest;
            r_ex_op_a     <= w_op_a;
            r_ex_op_b     <= w_op_b;
            r_ex_write_en <= op_writes_reg(opcode);
         end else begin
            // Bubble: drop write enable too so a consumer ignoring valid stays safe
            r_ex_valid    <= 1'b0;
            r_ex_write_en <= 1'b0;
         end
      end
   end

   assign ex_valid    = r_ex_valid;
   assign ex_opcode   = r_ex_opcode;
   assign ex_rdest    = r_ex_rdest;
   assign ex_op_a     = r_ex_op_a;
   assign ex_op_b     = r_ex_op_b;
   assign ex_write_en = r_ex_write_en;
   assign jump_taken  = r_jump_taken;
   assign jump_target = r_jump_target;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decode
// Description : Directed self-checking bench for instruction_decode
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [1:0] opcode;
   logic [2:0] rDest;
   logic [2:0] rSrc;
   logic [2:0] immediate_data;
   logic [7:0] jump_address;
   logic       stall;
   logic       in_ready;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic       ex_valid;
   logic [1:0] ex_opcode;
   logic [2:0] ex_rdest;
   logic [7:0] ex_op_a;
   logic [7:0] ex_op_b;
   logic       ex_write_en;
   logic       jump_taken;
   logic [7:0] jump_target;

   int n_checks = 0;
   int n_pass   = 0;

   instruction_decode #(
      .REG_W (8),
      .NREGS (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .opcode         (opcode),
      .rDest          (rDest),
      .rSrc           (rSrc),
      .immediate_data (immediate_data),
      .jump_address   (jump_address),
      .stall          (stall),
      .in_ready       (in_ready),
      .wb_en          (wb_en),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_rdest       (ex_rdest),
      .ex_op_a        (ex_op_a),
      .ex_op_b        (ex_op_b),
      .ex_write_en    (ex_write_en),
      .jump_taken     (jump_taken),
      .jump_target    (jump_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a fetched 8-bit instruction word as the split fields
   task automatic present(input logic [7:0] instr);
      in_valid       = 1'b1;
      opcode         = instr[7:6];
      rDest          = instr[5:3];
      rSrc           = instr[2:0];
      immediate_data = instr[2:0];
      jump_address   = {2'b00, instr[5:0]};
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; opcode = 2'b10; rDest = '0; rSrc = '0;
      immediate_data = '0; jump_address = '0; stall = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      step();
      step();
      reset = 1'b0;

      check("rst_ex_valid", ex_valid, 0);
      check("rst_jump_taken", jump_taken, 0);
      check("rst_jump_target", jump_target, 0);
      check("rst_in_ready", in_ready, 1);

      // LDI r1,#5
      present(8'b01001101);
      step();
      check("ldi_valid", ex_valid, 1);
      check("ldi_opcode", ex_opcode, 1);
      check("ldi_rdest", ex_rdest, 1);
      check("ldi_op_a", ex_op_a, 0);
      check("ldi_op_b", ex_op_b, 5);
      check("ldi_we", ex_write_en, 1);

      // Writeback r1=5, r2=3
      in_valid = 1'b0;
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'd5;
      step();
      check("idle_valid", ex_valid, 0);
      wb_addr = 3'd2; wb_data = 8'd3;
      step();
      wb_en = 1'b0;

      // ADD r1,r2
      present(8'b00001010);
      step();
      check("add_valid", ex_valid, 1);
      check("add_op_a", ex_op_a, 5);
      check("add_op_b", ex_op_b, 3);
      check("add_we", ex_write_en, 1);

      // ADD r1,r2 with same-cycle writeback r2=9
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'd9;
      step();
      wb_en = 1'b0;
      check("byp_op_a", ex_op_a, 5);
      check("byp_op_b", ex_op_b, 9);

      // JMP 0x05, then LDI r3,#7 squashed, then LDI r3,#7 accepted
      present(8'b11000101);
      step();
      check("jmp_taken", jump_taken, 1);
      check("jmp_target", jump_target, 8'h05);
      check("jmp_ex_valid", ex_valid, 0);
      present(8'b01011111);
      step();
      check("sq_taken", jump_taken, 0);
      check("sq_ex_valid", ex_valid, 0);
      check("sq_target_hold", jump_target, 8'h05);
      step();
      check("post_sq_valid", ex_valid, 1);
      check("post_sq_rdest", ex_rdest, 3);
      check("post_sq_op_b", ex_op_b, 7);

      // Stall three cycles with ADD r1,r2 presented
      present(8'b00001010);
      stall = 1'b1;
      #1;
      check("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_valid", ex_valid, 1);
         check("stall_rdest", ex_rdest, 3);
         check("stall_op_b", ex_op_b, 7);
      end
      stall = 1'b0;
      step();
      check("unstall_rdest", ex_rdest, 1);
      check("unstall_op_a", ex_op_a, 5);
      check("unstall_op_b", ex_op_b, 9);

      // Reset while squash is pending and registers hold data
      present(8'b11000101);
      step();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_jump_taken", jump_taken, 0);
      check("arst_ex_valid", ex_valid, 0);
      check("arst_op_a", ex_op_a, 0);
      check("arst_target", jump_target, 0);
      step();
      reset = 1'b0;
      present(8'b00001010);
      step();
      check("arst_add_valid", ex_valid, 1);
      check("arst_add_op_a", ex_op_a, 0);
      check("arst_add_op_b", ex_op_b, 0);

      // NOP then bubble
      present(8'b10110011);
      step();
      check("nop_valid", ex_valid, 1);
      check("nop_we", ex_write_en, 0);
      check("nop_opcode", ex_opcode, 2);
      check("nop_op_a", ex_op_a, 0);
      in_valid = 1'b0;
      step();
      check("bubble_valid", ex_valid, 0);

      // A squashed JMP must not redirect
      present(8'b11000101);
      step();
      present(8'b11001001);
      step();
      check("sq_jmp_taken", jump_taken, 0);
      check("sq_jmp_target", jump_target, 8'h05);
      present(8'b01010010);
      step();
      check("after_sq_jmp_valid", ex_valid, 1);
      check("after_sq_jmp_op_b", ex_op_b, 2);
      in_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_decode.md
# instruction_decode

Decode stage sitting directly downstream of `instruction_fetch`. It takes the already-split fields `opcode`, `rDest`, `rSrc`, `immediate_data` and `jump_address`, and owns the 8×8-bit register file. It resolves jumps back toward the PC logic and presents a registered ID/EX bundle (operands, destination, write enable) to the execute stage. A writeback port from downstream updates the register file, with same-cycle bypass.

## Interface
- `REG_W`, 8, register/data width
- `NREGS`, 8, register count (address width 3)
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `in_valid` input 1: fetch fields are a real instruction this cycle
- `opcode` input 2: 00 ADD, 01 LDI, 10 NOP, 11 JMP
- `rDest` input 3: destination / first source register
- `rSrc` input 3: second source register
- `immediate_data` input 3: LDI immediate
- `jump_address` input 8: JMP target
- `stall` input 1: execute stage cannot accept; hold ID/EX
- `in_ready` output 1: decode accepts this cycle; equals `~stall`
- `wb_en` input 1: writeback request
- `wb_addr` input 3: writeback register
- `wb_data` input 8: writeback value
- `ex_valid` output 1: ID/EX bundle valid
- `ex_opcode` output 2: registered opcode
- `ex_rdest` output 3: registered destination
- `ex_op_a` output 8: operand A
- `ex_op_b` output 8: operand B
- `ex_write_en` output 1: instruction writes `ex_rdest`
- `jump_taken` output 1: one-cycle pulse, PC loads `jump_target`
- `jump_target` output 8: registered jump address

## Operation
- Accept: `acc = in_valid & ~stall & ~squash`.
- ADD (00): `op_a = R[rDest]`, `op_b = R[rSrc]`, `write_en = 1`.
- LDI (01): `op_a = 0`, `op_b = {5'b0, immediate_data}`, `write_en = 1`.
- NOP (10): `ex_valid = 1`, `write_en = 0`, operands 0.
- JMP (11): handled entirely here, never sent to EX.
  - On acc: `ex_valid = 0`, `jump_taken = 1` and `jump_target = jump_address` next cycle.
  - `squash` is set.
- Squash: while `squash = 1`, the next `in_valid & ~stall` instruction (fetched before the PC redirect) is discarded. `squash` then clears. A squashed JMP does not jump. Stall keeps `squash` set.
- Register file: all 8 registers writable, no hardwired zero. Write on rising edge when `wb_en`.
- Read bypass: if `wb_en` and `wb_addr` equals the read address in the same cycle, the read returns `wb_data`.
- EX-to-EX forwarding is not this block's job; the execute stage owns it.
- Stall: all ID/EX outputs hold their value. `jump_taken` still deasserts after one cycle. Writeback proceeds regardless of stall.
- Reset (any time, including mid-squash): register file all 0. `ex_*` all 0, `jump_taken = 0`, `jump_target = 0`, `squash = 0`.

## Timing
- Latency: fields at cycle N produce `ex_*` valid from the edge ending cycle N (visible in N+1).
- JMP accepted at N: `jump_taken = 1` during N+1 only; instruction presented at N+1 is squashed.
- Writeback at edge N is visible to reads in N+1. During N itself it is visible via bypass.
- When not stalled and not accepting (`~in_valid` or squash), the next edge clears `ex_valid` to 0.
- `in_ready` is combinational from `stall`; no other input-to-output combinational paths.

## Structure
- Shared package `mips_pkg` holds:
  - `OP_ADD = 2'b00`, `OP_LDI = 2'b01`, `OP_NOP = 2'b10`, `OP_JMP = 2'b11`
  - `REG_W = 8`, `NREGS = 8`, `RADDR_W = 3`
- Sub-module `register_file`: two async read ports, one sync write port, write-to-read bypass, async reset to zero.
- Top level holds decode logic, squash flag, jump registers and the ID/EX register.

## Test plan
- Reset, then LDI r1,#5 (`01001101`) → next cycle `ex_valid = 1`, `ex_rdest = 1`, `ex_op_a = 0`, `ex_op_b = 5`, `ex_write_en = 1`.
- Writeback r1 = 5, r2 = 3, then ADD r1,r2 (`00001010`) → `ex_op_a = 5`, `ex_op_b = 3`. Repeat with `wb_en`/`wb_addr = 2`/`wb_data = 9` in the same cycle → `ex_op_b = 9` (bypass).
- JMP 0x05 (`11000101`) at cycle N, LDI at N+1 → `jump_taken = 1` and `jump_target = 0x05` in N+1 only. No `ex_valid` for either instruction. LDI at N+2 passes.
- `stall = 1` for 3 cycles with a valid ADD presented → `in_ready = 0` and `ex_*` frozen. After release, the ADD appears one cycle later.
- Assert `reset` mid-squash, with nonzero registers → all outputs 0 immediately (async). After release, ADD r1,r2 reads 0,0 and the next instruction is not squashed.
- NOP (`10xxxxxx`) → `ex_valid = 1`, `ex_write_en = 0`. `in_valid = 0` → `ex_valid = 0` next cycle.
